// File: rtl/ssyfifo_rd_gearbox_pkg.sv
// ----------------------------------------------------------------------------
// ssyfifo_rd_gearbox_pkg
// Shared configuration for the pcs25g read-side FIFO gearbox.
//   - Default input word width (GBX_WIDTH) and output slice width
//     (GBX_OUT_WIDTH), plus the default slice counter width.
//   - gbx_ratio(): number of output slices per input word.
//   - gbx_legal(): true when the word width splits into whole slices.
// No ports (package).
// ----------------------------------------------------------------------------
package ssyfifo_rd_gearbox_pkg;

   localparam int GBX_WIDTH     = 192;
   localparam int GBX_OUT_WIDTH = 64;
   localparam int GBX_CNTW      = 2;

   // Slices per word; only meaningful when gbx_legal() holds.
   function automatic int gbx_ratio(input int width, input int out_width);
      return width / out_width;
   endfunction

   // The word must split into an integral number of non-empty slices.
   function automatic bit gbx_legal(input int width, input int out_width);
      return (out_width > 0) && ((width % out_width) == 0);
   endfunction

endpackage

// File: rtl/ssyfifo_rd_gearbox_slice_sel.sv
// ----------------------------------------------------------------------------
// ssyfifo_rd_gearbox_slice_sel (module ssyfifo_gbx_slice_sel)
// Combinational RATIO-way slice multiplexer: picks slice cnt out of the held
// word.
// Optional macro SSYFIFO_RD_GEARBOX_MSB_FIRST_EN:
//   defined   -> slice k = hold[WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH] (MSB first)
//   undefined -> slice k = hold[k*OUT_WIDTH +: OUT_WIDTH]         (LSB first)
// Ports:
//   hold   in  WIDTH      held input word
//   cnt    in  CNTW       slice index
//   slice  out OUT_WIDTH  selected slice (zero for an out-of-range index)
// ----------------------------------------------------------------------------
module ssyfifo_gbx_slice_sel
   import ssyfifo_rd_gearbox_pkg::*;
#(
   parameter int WIDTH     = GBX_WIDTH,
   parameter int OUT_WIDTH = GBX_OUT_WIDTH,
   parameter int RATIO     = gbx_ratio(GBX_WIDTH, GBX_OUT_WIDTH),
   parameter int CNTW      = GBX_CNTW
) (
   input  logic [WIDTH-1:0]     hold,
   input  logic [CNTW-1:0]      cnt,
   output logic [OUT_WIDTH-1:0] slice
);

   logic [OUT_WIDTH-1:0] slices_s [RATIO];
   logic [OUT_WIDTH-1:0] slice_s;

   for (genvar k = 0; k < RATIO; k++) begin : g_slice
`ifdef SSYFIFO_RD_GEARBOX_MSB_FIRST_EN
      assign slices_s[k] = hold[WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
      assign slices_s[k] = hold[k*OUT_WIDTH +: OUT_WIDTH];
`endif
   end

   // Index the slice table; the extra compare bit keeps the bound check
   // correct when RATIO == 2**CNTW.
   always_comb begin
      slice_s = '0;
      if ({1'b0, cnt} < (CNTW+1)'(RATIO)) begin
         slice_s = slices_s[cnt];
      end else begin
         slice_s = '0;
      end
   end

   assign slice = slice_s;

endmodule

// File: rtl/ssyfifo_rd_gearbox.sv
// ----------------------------------------------------------------------------
// ssyfifo_rd_gearbox
// Read-side consumer of the pcs25g dual-clock FIFO. Pops WIDTH-bit words via
// the FIFO idle/datavalid handshake and emits each as RATIO consecutive
// OUT_WIDTH-bit slices with downstream backpressure. Zero-bubble: the last
// slice of one word and the pop of the next can happen in the same cycle.
// Optional macro SSYFIFO_RD_GEARBOX_MSB_FIRST_EN: emit the MSB slice first
// (default: LSB slice first). Only out_data ordering changes.
// Ports:
//   clk            in   read clock (FIFO read side)
//   rst_n          in   asynchronous active-low reset
//   in_enable      in   block enable; low deasserts handshakes, holds state
//   in_data        in   WIDTH word from the FIFO
//   in_datavalid   in   FIFO pop strobe; a word is taken every cycle it is 1
//   out_idle       out  ready to the FIFO
//   out_data       out  current OUT_WIDTH slice
//   out_datavalid  out  slice valid
//   out_last       out  final slice of the word
//   in_idle        in   downstream ready
// ----------------------------------------------------------------------------
module ssyfifo_rd_gearbox
   import ssyfifo_rd_gearbox_pkg::*;
#(
   parameter int WIDTH     = GBX_WIDTH,
   parameter int OUT_WIDTH = GBX_OUT_WIDTH,
   parameter int CNTW      = GBX_CNTW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_enable,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_datavalid,
   output logic                 out_idle,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_datavalid,
   output logic                 out_last,
   input  logic                 in_idle
);

   localparam int RATIO = gbx_ratio(WIDTH, OUT_WIDTH);
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(RATIO - 1);

   if (!gbx_legal(WIDTH, OUT_WIDTH)) begin : g_bad_ratio
      $error("ssyfifo_rd_gearbox: WIDTH must be a multiple of OUT_WIDTH");
   end
   if ((2 ** CNTW) < RATIO) begin : g_bad_cntw
      $error("ssyfifo_rd_gearbox: CNTW too narrow for RATIO");
   end

   logic [WIDTH-1:0] hold_r;
   logic             full_r;
   logic [CNTW-1:0]  cnt_r;

   logic [WIDTH-1:0] hold_nxt_s;
   logic             full_nxt_s;
   logic [CNTW-1:0]  cnt_nxt_s;

   logic             last_s;
   logic             valid_s;
   logic             accept_s;
   logic             consume_s;

   assign last_s    = (cnt_r == LAST_CNT);
   assign valid_s   = in_enable && full_r;
   assign accept_s  = in_enable && in_datavalid;
   assign consume_s = valid_s && in_idle;

   // Ready must not look at in_datavalid: the FIFO derives datavalid from it.
   assign out_idle      = in_enable && (!full_r || (last_s && in_idle));
   assign out_datavalid = valid_s;
   assign out_last      = valid_s && last_s;

   // Next state: a pop always wins (it reloads cnt to 0 and keeps full set),
   // which also covers the zero-bubble last-slice-plus-pop cycle.
   always_comb begin
      hold_nxt_s = hold_r;
      full_nxt_s = full_r;
      cnt_nxt_s  = cnt_r;
      if (accept_s) begin
         hold_nxt_s = in_data;
         full_nxt_s = 1'b1;
         cnt_nxt_s  = '0;
      end else if (consume_s) begin
         if (last_s) begin
            full_nxt_s = 1'b0;
            cnt_nxt_s  = '0;
         end else begin
            cnt_nxt_s  = cnt_r + CNTW'(1);
         end
      end else begin
         hold_nxt_s = hold_r;
         full_nxt_s = full_r;
         cnt_nxt_s  = cnt_r;
      end
   end

   // State registers; reset discards any partially emitted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_r <= '0;
         full_r <= 1'b0;
         cnt_r  <= '0;
      end else begin
         hold_r <= hold_nxt_s;
         full_r <= full_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   ssyfifo_gbx_slice_sel #(
      .WIDTH     (WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .RATIO     (RATIO),
      .CNTW      (CNTW)
   ) u_slice_sel (
      .hold  (hold_r),
      .cnt   (cnt_r),
      .slice (out_data)
   );

endmodule

// File: tb/tb_ssyfifo_rd_gearbox.sv
// ----------------------------------------------------------------------------
// tb_ssyfifo_rd_gearbox
// Directed bench for ssyfifo_rd_gearbox (192 -> 3 x 64) followed by a short
// randomised backpressure run against a slice queue. Honors
// SSYFIFO_RD_GEARBOX_MSB_FIRST_EN for the expected slice order.
// ----------------------------------------------------------------------------
module tb_ssyfifo_rd_gearbox;

   logic         clk;
   logic         rst_n;
   logic         in_enable;
   logic [191:0] in_data;
   logic         in_datavalid;
   logic         out_idle;
   logic [63:0]  out_data;
   logic         out_datavalid;
   logic         out_last;
   logic         in_idle;

   int chk_cnt;
   int pass_cnt;

   logic [63:0] exp_q [$];

   ssyfifo_rd_gearbox dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_enable     (in_enable),
      .in_data       (in_data),
      .in_datavalid  (in_datavalid),
      .out_idle      (out_idle),
      .out_data      (out_data),
      .out_datavalid (out_datavalid),
      .out_last      (out_last),
      .in_idle       (in_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_slice(input logic [191:0] w, input int k);
`ifdef SSYFIFO_RD_GEARBOX_MSB_FIRST_EN
      return w[191-k*64 -: 64];
`else
      return w[k*64 +: 64];
`endif
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop one word on the next edge; returns just after that edge, settled.
   task automatic pop_word(input logic [191:0] w);
      chk("pop_legal", out_idle, 1'b1);
      in_data      = w;
      in_datavalid = 1'b1;
      tick();
      in_datavalid = 1'b0;
      #1;
   endtask

   task automatic chk_slice(input string tag, input logic [191:0] w, input int k);
      chk({tag, "_data"}, out_data, exp_slice(w, k));
      chk({tag, "_dv"}, out_datavalid, 1'b1);
      chk({tag, "_last"}, out_last, (k == 2) ? 1'b1 : 1'b0);
   endtask

   initial begin
      logic [191:0] w_abc;
      logic [191:0] w0;
      logic [191:0] w1;
      logic [191:0] wr;
      int           words_left;
      bit           done;

      chk_cnt      = 0;
      pass_cnt     = 0;
      rst_n        = 1'b0;
      in_enable    = 1'b1;
      in_data      = '0;
      in_datavalid = 1'b0;
      in_idle      = 1'b1;
      w_abc = {64'h0000_0000_0000_000C, 64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A};
      w0    = {64'h0333_3333_3333_3330, 64'h0222_2222_2222_2220, 64'h0111_1111_1111_1110};
      w1    = {64'hF666_6666_6666_666F, 64'hF555_5555_5555_555F, 64'hF444_4444_4444_444F};

      // Reset state
      #2;
      chk("rst_idle", out_idle, 1'b1);
      chk("rst_dv", out_datavalid, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_data", out_data, 64'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single word, slices on three consecutive cycles
      pop_word(w_abc);
      chk_slice("w_s0", w_abc, 0);
      chk("w_s0_idle", out_idle, 1'b0);
      tick();
      chk_slice("w_s1", w_abc, 1);
      tick();
      chk_slice("w_s2", w_abc, 2);
      chk("w_s2_idle", out_idle, 1'b1);
`ifdef SSYFIFO_RD_GEARBOX_MSB_FIRST_EN
      chk("w_s2_abs", out_data, 64'h0000_0000_0000_000A);
`else
      chk("w_s2_abs", out_data, 64'h0000_0000_0000_000C);
`endif
      tick();
      chk("w_end_dv", out_datavalid, 1'b0);
      chk("w_end_idle", out_idle, 1'b1);

      // Back-to-back words with no bubble
      pop_word(w0);
      chk_slice("b0_s0", w0, 0);
      tick();
      chk_slice("b0_s1", w0, 1);
      tick();
      chk_slice("b0_s2", w0, 2);
      pop_word(w1);
      chk_slice("b1_s0", w1, 0);
      tick();
      chk_slice("b1_s1", w1, 1);
      tick();
      chk_slice("b1_s2", w1, 2);
      tick();
      chk("b_end_dv", out_datavalid, 1'b0);

      // Downstream stall at slice 1
      pop_word(w_abc);
      tick();
      in_idle = 1'b0;
      #1;
      chk("st_idle0", out_idle, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_slice("st_hold", w_abc, 1);
         chk("st_idle", out_idle, 1'b0);
      end
      in_idle = 1'b1;
      #1;
      chk_slice("st_res1", w_abc, 1);
      tick();
      chk_slice("st_res2", w_abc, 2);
      tick();
      chk("st_end_dv", out_datavalid, 1'b0);

      // Enable dropped at slice 1
      pop_word(w1);
      tick();
      chk_slice("en_s1", w1, 1);
      in_enable = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("en_dv", out_datavalid, 1'b0);
         chk("en_idle", out_idle, 1'b0);
         chk("en_last", out_last, 1'b0);
         tick();
      end
      in_enable = 1'b1;
      #1;
      chk_slice("en_res1", w1, 1);
      tick();
      chk_slice("en_res2", w1, 2);
      tick();
      chk("en_end_dv", out_datavalid, 1'b0);

      // Asynchronous reset mid-word
      pop_word(w0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_dv", out_datavalid, 1'b0);
      chk("ar_idle", out_idle, 1'b1);
      chk("ar_data", out_data, 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_post_dv", out_datavalid, 1'b0);

      // Random backpressure against a slice queue
      words_left = 60;
      for (int c = 0; c < 400; c++) begin
         tick();
         in_datavalid = 1'b0;
         in_idle      = ($urandom_range(0, 3) != 0);
         #1;
         if (out_idle && (words_left > 0) && ($urandom_range(0, 3) != 0)) begin
            wr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_data      = wr;
            in_datavalid = 1'b1;
            words_left--;
            for (int k = 0; k < 3; k++) exp_q.push_back(exp_slice(wr, k));
         end
         if (out_datavalid && in_idle) begin
            if (exp_q.size() > 0) begin
               chk("sb_slice", out_data, exp_q.pop_front());
            end else begin
               chk("sb_spurious", out_datavalid, 1'b0);
            end
         end
      end
      tick();
      in_datavalid = 1'b0;
      in_idle      = 1'b1;
      done         = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         #1;
         if (out_datavalid) begin
            if (exp_q.size() > 0) begin
               chk("sb_drain", out_data, exp_q.pop_front());
            end else begin
               chk("sb_drain_spurious", out_datavalid, 1'b0);
            end
         end else begin
            done = 1'b1;
         end
         tick();
      end
      chk("sb_words_sent", words_left, 0);
      chk("sb_empty", exp_q.size(), 0);
      chk("sb_end_dv", out_datavalid, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
